// File: rtl/sat_search_if.sv
// Handshake bundle between the assignment sequencer and its host / PLA evaluator.
//   start      host -> sequencer, begin a search (sampled only while idle)
//   sat_in     PLA  -> sequencer, satisfied bit for the candidate issued LAT cycles earlier
//   cand       sequencer -> PLA, candidate assignment
//   cand_valid sequencer -> PLA, cand is live this cycle
//   busy       searching or draining
//   done       one-cycle pulse when found/solution/evals are final
//   found      a satisfying assignment was seen
//   solution   first satisfying assignment (0 if none)
//   evals      number of candidate results consumed (N+1 bits)
// The slave modport is the sequencer; the master modport is the host/evaluator side.
interface sat_search_if #(
    parameter int N = 10
);
    logic         start;
    logic         sat_in;
    logic [N-1:0] cand;
    logic         cand_valid;
    logic         busy;
    logic         done;
    logic         found;
    logic [N-1:0] solution;
    logic [N:0]   evals;

    modport master (
        output start, sat_in,
        input  cand, cand_valid, busy, done, found, solution, evals
    );

    modport slave (
        input  start, sat_in,
        output cand, cand_valid, busy, done, found, solution, evals
    );
endinterface

// File: rtl/sat_search_ctrl.sv
// Brute-force assignment sequencer feeding a 3SAT PLA evaluator.
// Issues candidates 0..2^N-1, one per cycle, pairs each returning sat_in with
// the candidate that produced it (LAT = 0..2 cycles of evaluator latency) and
// stops at the first satisfying assignment or after the last candidate.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    sat_search_if.slave (start, sat_in in; cand, cand_valid, busy,
//          done, found, solution, evals out)
//
// state  | meaning
// IDLE   | waiting for start, previous results held
// SEARCH | issuing one candidate per cycle and consuming results
// DRAIN  | last candidate issued, consuming the LAT results still in flight
// DONE   | results final, done pulses for this one cycle
module sat_search_ctrl #(
    parameter int N   = 10,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         reset,
    sat_search_if.slave  bus
);

    localparam logic [N-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t       state, state_next;
    logic [N-1:0] cand_q, cand_next;
    logic [N-1:0] solution_q, solution_next;
    logic         found_q, found_next;
    logic         done_q, done_next;
    logic [N:0]   evals_q, evals_next;

    logic         issue;
    logic         arr_valid;
    logic [N-1:0] arr_tag;
    logic         hit;

    assign issue = (state == S_SEARCH);
    assign hit   = arr_valid && bus.sat_in &&
                   ((state == S_SEARCH) || (state == S_DRAIN));

    // Result pairing: a zero-latency PLA answers for the candidate on the bus
    // right now; otherwise the candidate rides a LAT-deep delay line.
    generate
        if (LAT == 0) begin : g_comb
            assign arr_valid = (state == S_SEARCH);
            assign arr_tag   = cand_q;
        end else begin : g_pipe
            logic [N-1:0] tag_pipe [LAT];
            logic [LAT-1:0] vld_pipe;

            always_ff @(posedge clk) begin
                if (reset || hit) begin
                    vld_pipe <= '0;
                    for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
                end else begin
                    vld_pipe[0] <= issue;
                    tag_pipe[0] <= cand_q;
                    for (int i = 1; i < LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        tag_pipe[i] <= tag_pipe[i-1];
                    end
                end
            end

            assign arr_valid = vld_pipe[LAT-1];
            assign arr_tag   = tag_pipe[LAT-1];
        end
    endgenerate

    always_comb begin
        state_next    = state;
        cand_next     = cand_q;
        found_next    = found_q;
        solution_next = solution_q;
        evals_next    = evals_q;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next    = S_SEARCH;
                    cand_next     = '0;
                    found_next    = 1'b0;
                    solution_next = '0;
                    evals_next    = '0;
                end
            end
            S_SEARCH: begin
                if (arr_valid) evals_next = evals_q + 1'b1;
                if (hit) begin
                    found_next    = 1'b1;
                    solution_next = arr_tag;
                    state_next    = S_DONE;
                end else if (cand_q == ALL_ONES) begin
                    // cand never wraps; with no latency the last result is already in
                    state_next = (LAT == 0) ? S_DONE : S_DRAIN;
                end else begin
                    cand_next = cand_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (arr_valid) evals_next = evals_q + 1'b1;
                if (hit) begin
                    found_next    = 1'b1;
                    solution_next = arr_tag;
                    state_next    = S_DONE;
                end else if (arr_valid && (arr_tag == ALL_ONES)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        done_next = (state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cand_q     <= '0;
            found_q    <= 1'b0;
            solution_q <= '0;
            evals_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            cand_q     <= cand_next;
            found_q    <= found_next;
            solution_q <= solution_next;
            evals_q    <= evals_next;
            done_q     <= done_next;
        end
    end

    assign bus.cand       = cand_q;
    assign bus.cand_valid = (state == S_SEARCH);
    assign bus.busy       = (state == S_SEARCH) || (state == S_DRAIN);
    assign bus.done       = done_q;
    assign bus.found      = found_q;
    assign bus.solution   = solution_q;
    assign bus.evals      = evals_q;

endmodule

// File: tb/tb_sat_search_ctrl.sv
module tb_sat_search_ctrl;

    localparam int N = 4;

    logic clk;
    logic reset;

    sat_search_if #(.N(N)) bus0 ();
    sat_search_if #(.N(N)) bus2 ();

    sat_search_ctrl #(.N(N), .LAT(0)) u_lat0 (.clk(clk), .reset(reset), .bus(bus0));
    sat_search_ctrl #(.N(N), .LAT(2)) u_lat2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PLA stand-ins: a truth table over all 2^N assignments; the LAT=2 one
    // registers its input twice.
    logic [15:0]  mask [2];
    logic         start_r [2];
    logic [N-1:0] c1, c2;

    always_ff @(posedge clk) begin
        c1 <= bus2.cand;
        c2 <= c1;
    end

    assign bus0.start  = start_r[0];
    assign bus2.start  = start_r[1];
    assign bus0.sat_in = mask[0][bus0.cand];
    assign bus2.sat_in = mask[1][c2];

    logic [N-1:0] cand_o [2];
    logic         cv_o [2], busy_o [2], done_o [2], found_o [2];
    logic [N-1:0] sol_o [2];
    logic [N:0]   evals_o [2];

    assign cand_o[0]  = bus0.cand;       assign cand_o[1]  = bus2.cand;
    assign cv_o[0]    = bus0.cand_valid; assign cv_o[1]    = bus2.cand_valid;
    assign busy_o[0]  = bus0.busy;       assign busy_o[1]  = bus2.busy;
    assign done_o[0]  = bus0.done;       assign done_o[1]  = bus2.done;
    assign found_o[0] = bus0.found;      assign found_o[1] = bus2.found;
    assign sol_o[0]   = bus0.solution;   assign sol_o[1]   = bus2.solution;
    assign evals_o[0] = bus0.evals;      assign evals_o[1] = bus2.evals;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the lowest satisfying assignment, or -1.
    function automatic int first_hit(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic check_idle_zero(input int w, input string tag);
        chk({tag, "_cand"},  32'(cand_o[w]),  0);
        chk({tag, "_cv"},    32'(cv_o[w]),    0);
        chk({tag, "_busy"},  32'(busy_o[w]),  0);
        chk({tag, "_done"},  32'(done_o[w]),  0);
        chk({tag, "_found"}, 32'(found_o[w]), 0);
        chk({tag, "_sol"},   32'(sol_o[w]),   0);
        chk({tag, "_evals"}, 32'(evals_o[w]), 0);
    endtask

    // Sample the search from the cycle after the start-sampling edge
    // (cycle 1) until done, and compare with the model.
    task automatic observe(input int w, input logic [15:0] m, input string tag);
        int lat, k, cyc, vcnt, done_cyc, exp_cyc, exp_v;
        bit seq_ok;
        lat = (w == 0) ? 0 : 2;
        k   = first_hit(m);
        cyc = 1; vcnt = 0; done_cyc = -1; seq_ok = 1'b1;
        while (cyc <= 60) begin
            if (cv_o[w]) begin
                if (32'(cand_o[w]) != vcnt) seq_ok = 1'b0;
                vcnt++;
            end
            if (done_o[w]) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        exp_cyc = (k >= 0) ? 2 + k + lat : 1 + 16 + lat;
        exp_v   = (k >= 0) ? (((k + lat + 1) < 16) ? k + lat + 1 : 16) : 16;
        chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
        chk({tag, "_found"},      32'(found_o[w]), (k >= 0) ? 1 : 0);
        chk({tag, "_solution"},   32'(sol_o[w]),   (k >= 0) ? k : 0);
        chk({tag, "_evals"},      32'(evals_o[w]), (k >= 0) ? k + 1 : 16);
        chk({tag, "_valid_cnt"},  vcnt, exp_v);
        chk({tag, "_cand_seq"},   32'(seq_ok), 1);
    endtask

    task automatic run_search(input int w, input logic [15:0] m, input string tag);
        int k;
        k = first_hit(m);
        @(negedge clk);
        mask[w]    = m;
        start_r[w] = 1'b1;
        @(posedge clk); #1;
        start_r[w] = 1'b0;
        observe(w, m, tag);
        @(posedge clk); #1;
        chk({tag, "_post_busy"},  32'(busy_o[w]),  0);
        chk({tag, "_post_done"},  32'(done_o[w]),  0);
        chk({tag, "_post_found"}, 32'(found_o[w]), (k >= 0) ? 1 : 0);
        chk({tag, "_post_evals"}, 32'(evals_o[w]), (k >= 0) ? k + 1 : 16);
    endtask

    task automatic run_hold(input int w, input logic [15:0] m, input string tag);
        int k;
        k = first_hit(m);
        @(negedge clk);
        mask[w]    = m;
        start_r[w] = 1'b1;
        @(posedge clk); #1;
        observe(w, m, {tag, "_a"});
        @(posedge clk); #1;
        // start still high: DONE must not restart, results held in IDLE
        chk({tag, "_idle_busy"},  32'(busy_o[w]),  0);
        chk({tag, "_idle_found"}, 32'(found_o[w]), (k >= 0) ? 1 : 0);
        chk({tag, "_idle_sol"},   32'(sol_o[w]),   (k >= 0) ? k : 0);
        @(posedge clk); #1;
        chk({tag, "_restart_busy"},  32'(busy_o[w]),  1);
        chk({tag, "_restart_cand"},  32'(cand_o[w]),  0);
        chk({tag, "_restart_evals"}, 32'(evals_o[w]), 0);
        chk({tag, "_restart_found"}, 32'(found_o[w]), 0);
        start_r[w] = 1'b0;
        // restart edge is cycle 1 of the second search
        observe(w, m, {tag, "_b"});
        @(posedge clk); #1;
    endtask

    task automatic run_reset(input int w, input logic [15:0] m, input string tag);
        int guard;
        bit quiet;
        @(negedge clk);
        mask[w]    = m;
        start_r[w] = 1'b1;
        @(posedge clk); #1;
        start_r[w] = 1'b0;
        guard = 0;
        while (!(cv_o[w] && cand_o[w] == 4'd5) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "_reach_cand5"}, 32'(guard < 40), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_zero(w, {tag, "_rst"});
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy_o[w] || done_o[w] || found_o[w] || evals_o[w] != 0) quiet = 1'b0;
        end
        chk({tag, "_no_stale"}, 32'(quiet), 1);
    endtask

    function automatic logic [15:0] rand_mask();
        int mode;
        mode = $urandom_range(0, 3);
        case (mode)
            0:       return 16'h0;
            1:       return 16'(1 << $urandom_range(0, 15));
            2:       return 16'($urandom & $urandom & $urandom);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        mask[0]    = 16'h0;
        mask[1]    = 16'h0;
        start_r[0] = 1'b0;
        start_r[1] = 1'b0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero(0, "reset_l0");
        check_idle_zero(1, "reset_l2");
        reset = 1'b0;
        @(posedge clk); #1;

        run_search(0, 16'h0040, "l0_hit6");
        run_search(0, 16'h0000, "l0_none");
        run_search(1, 16'h0201, "l2_hit0");
        run_search(1, 16'h8000, "l2_hit15");
        run_search(1, 16'h0000, "l2_none");

        run_reset(0, 16'h0020, "l0_reset");
        run_search(0, 16'h0400, "l0_after_rst");
        run_reset(1, 16'h0010, "l2_reset");
        run_search(1, 16'h0400, "l2_after_rst");

        run_hold(0, 16'h0008, "l0_hold");
        run_hold(1, 16'h0004, "l2_hold");

        for (int i = 0; i < 6; i++) begin
            run_search(0, rand_mask(), $sformatf("l0_rand%0d", i));
            run_search(1, rand_mask(), $sformatf("l2_rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sat_search_ctrl.md
Name: sat_search_ctrl

Overview:
Brute-force assignment sequencer placed directly upstream of the 3SAT PLA evaluator. On start it drives candidate variable assignments 0..2^N-1 onto the PLA inputs, one per cycle, and samples the PLA's single satisfied bit. It stops at the first satisfying assignment, or after exhausting the space. It reports found/solution/evaluation count, and supports 0–2 cycles of evaluator latency so that a registered PLA can be used.

Parameters:
N, 10, number of variables; width of the candidate assignment.
LAT, 0, cycles from cand presentation to the matching sat_in; legal values 0, 1, 2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
start  input  1  begin search; sampled only in IDLE
cand  output  N  candidate assignment to PLA inputs
cand_valid  output  1  cand carries a live candidate this cycle
sat_in  input  1  PLA output for the candidate issued LAT cycles earlier
busy  output  1  high in SEARCH and DRAIN
done  output  1  one-cycle pulse when the result is final
found  output  1  a satisfying assignment was found
solution  output  N  first satisfying assignment (0 if none)
evals  output  N+1  number of candidates whose result was observed

Behaviour:
- Reset (synchronous, active-high): state=IDLE, cand=0, cand_valid=0, busy=0, done=0, found=0, solution=0, evals=0, in-flight pipe cleared. This applies from any state, including mid-search; in-flight results are discarded.
- All outputs are registered except cand_valid and busy, which are decoded from state.
- States: IDLE, SEARCH, DRAIN, DONE.
- IDLE:
  - start=1 -> SEARCH; cand=0; found, solution and evals cleared.
  - Previous results are held until that start.
  - start=0 -> stay in IDLE.
- SEARCH:
  - cand_valid=1; cand increments by 1 each cycle.
  - A delay line of depth LAT carries (tag=cand, valid) so each sat_in is paired with its candidate. For LAT=0 the pair is cand itself.
  - Each cycle a tagged valid result arrives: evals += 1. If sat_in=1: found=1, solution=tag, go to DONE, stop issuing, invalidate the delay line.
  - A hit takes priority over every other transition.
  - When cand=2^N-1 is issued and has no hit: with LAT=0 go to DONE (found=0); with LAT>0 go to DRAIN.
- DRAIN:
  - cand_valid=0; cand holds at its last value.
  - Consume the remaining LAT results using the same hit and evals rules as SEARCH.
  - On a hit -> DONE. Once the final result is consumed with no hit -> DONE with found=0, solution=0.
- DONE: done=1 for exactly this cycle, then IDLE. start is ignored in DONE.
- sat_in is ignored whenever no valid tag is arriving (IDLE, DONE, first LAT cycles of SEARCH).
- start is ignored while busy.
- Latency, measured from the start sample edge:
  - hit on candidate k: done is high in cycle 2+k+LAT, with evals=k+1.
  - exhaustion: done is high in cycle 2+2^N-1+LAT, with evals=2^N.
- Arithmetic:
  - evals is N+1 bits so that 2^N does not wrap.
  - cand never wraps; issuing stops at all-ones.
  - The only wrap risk is an unsatisfied counter rollover, which the exhaustion rule prevents.

Test Plan:
- N=4, LAT=0; sat_in = (cand==4'd6); start pulse at cycle 0 -> done at cycle 8, found=1, solution=6, evals=7, busy low after DONE.
- N=4, LAT=0; sat_in tied 0 -> done at cycle 17, found=0, solution=0, evals=16. cand_valid is high for exactly 16 cycles and cand never exceeds 15.
- N=4, LAT=2; sat_in = registered-twice (cand==4'd0 or cand==4'd9) -> solution=0, found=1, evals=1, done at cycle 4. Candidates 1 and 2 already issued are discarded.
- N=4, LAT=2; sat only for cand=15 -> hit is captured in DRAIN: found=1, solution=15, evals=16, done at cycle 19.
- Assert reset while in SEARCH at cand=5 -> next cycle IDLE with all outputs 0. A following start restarts from cand=0 with no stale hit.
- start held high through SEARCH and DONE -> no restart while busy or in DONE. The new search begins only on the first IDLE cycle; results stay stable until that cycle.
